cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
Two-requester arbiter for a single physical memory port. Serves line-fill misses from the icache and line-fill/writeback traffic from the dcache. Sits between the two L1 caches (fed by the fetch and mem pipeline stages) and pmem/L2. Priority goes to the dcache, with a starvation guard for the icache. Requests are latched at grant and responses are registered.

Parameters:
ADDR_WIDTH, 16, byte address width (lc3b_word)
LINE_WIDTH, 128, cache line width in bits (lc3b_line)
OFFSET_BITS, 4, line-offset bits forced to zero on pmem_address
MAX_D_STREAK, 3, consecutive contested dcache grants allowed before the icache must win

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
icache_pmem_address  in  ADDR_WIDTH  icache miss address
icache_pmem_read  in  1  icache line-read request, level, held until resp
icache_pmem_resp  out  1  one-cycle pulse, icache_pmem_rdata valid
icache_pmem_rdata  out  LINE_WIDTH  registered fill line for icache
dcache_pmem_address  in  ADDR_WIDTH  dcache miss/writeback address
dcache_pmem_read  in  1  dcache line-read request, level
dcache_pmem_write  in  1  dcache line-write request, level
dcache_pmem_wdata  in  LINE_WIDTH  writeback line
dcache_pmem_resp  out  1  one-cycle pulse, dcache transaction done
dcache_pmem_rdata  out  LINE_WIDTH  registered fill line for dcache
pmem_address  out  ADDR_WIDTH  line-aligned address to memory
pmem_read  out  1  memory read strobe, level
pmem_write  out  1  memory write strobe, level
pmem_wdata  out  LINE_WIDTH  latched write line
pmem_rdata  in  LINE_WIDTH  memory read line
pmem_resp  in  1  memory done, one cycle
arb_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE; pmem_read/pmem_write/both resp outputs=0.
  - pmem_address, pmem_wdata and rdata buffers=0; d_streak=0.
  - An in-flight pmem transaction is abandoned; memory must ignore a dropped strobe.
- States: IDLE, I_BUSY, D_BUSY, I_RESP, D_RESP.
- IDLE, per request combination:
  - Only icache_pmem_read -> grant I, go I_BUSY.
  - Only dcache read or write -> grant D, go D_BUSY.
  - Both pending -> grant D unless d_streak==MAX_D_STREAK, in which case grant I.
  - No request -> stay IDLE.
- Grant edge latches:
  - Address with low OFFSET_BITS cleared.
  - Op type: dcache write wins if dcache read and write are both high.
  - wdata.
  - pmem strobes rise the cycle after grant; latched values are held until pmem_resp regardless of requester input changes.
- d_streak:
  - +1 on a D grant while icache_pmem_read is also high, saturating at MAX_D_STREAK.
  - Cleared on any I grant.
  - Unchanged on an uncontested D grant.
- I_BUSY / D_BUSY:
  - pmem_read or pmem_write asserted continuously.
  - On pmem_resp: capture pmem_rdata into that requester's buffer (writes capture nothing); deassert strobes next cycle; go *_RESP.
- I_RESP / D_RESP:
  - The matching *_pmem_resp is high for exactly one cycle, then go IDLE.
  - Requesters must drop their request in the cycle after resp, so IDLE never re-grants a finished request.
- Latency: grant at edge 0, strobe from cycle 1, resp pulse the cycle after pmem_resp. Best case is 3 cycles request-to-resp with a 1-cycle memory.
- rdata outputs hold their last captured value until the next capture for that requester.
- pmem_resp outside a BUSY state is ignored.
- Never more than one outstanding pmem transaction; at most one resp output high in any cycle.

Decomposition:
- lc3b_types additions:
  - lc3b_line typedef (logic [127:0]).
  - arb_state_t enum {IDLE, I_BUSY, D_BUSY, I_RESP, D_RESP}.
  - Constant MAX_D_STREAK default.
- One sub-module, arb_priority:
  - Combinational grant select from the two request lines and d_streak.
  - Owns the saturating d_streak register (clk/reset).
- The top level holds the FSM, latches and response buffers.

Test Plan:
- Lone icache read, addr 0x1237, pmem_resp 2 cycles after strobe with rdata=0xA5..A5 -> pmem_address=0x1230, pmem_read high 2 cycles, icache_pmem_resp one pulse, icache_pmem_rdata=0xA5..A5.
- Simultaneous icache read 0x0100 and dcache write 0x2000 -> D served first (pmem_write, wdata matches), then I served; d_streak=1 after D grant, 0 after I grant.
- icache held pending while dcache issues 5 back-to-back reads, MAX_D_STREAK=3 -> grant order D,D,D,I,D,D.
- dcache read and write both high, addr 0x3008 -> pmem_write only, pmem_address=0x3000, dcache_pmem_rdata unchanged.
- Reset asserted mid-D_BUSY -> pmem_write falls same cycle (async), no resp pulse, arb_busy=0; next request is served normally.
- Spurious pmem_resp in IDLE -> no resp outputs, state stays IDLE.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory-port arbiter.
package cache_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF   = 16;
  localparam int LINE_WIDTH_DEF   = 128;
  localparam int OFFSET_BITS_DEF  = 4;
  localparam int MAX_D_STREAK_DEF = 3;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    I_RESP = 3'd3,
    D_RESP = 3'd4
  } arb_state_t;

  // Plain-vector state constants so the FSM register stays a simple logic vector.
  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_I_BUSY = 3'(I_BUSY);
  localparam logic [2:0] ST_D_BUSY = 3'(D_BUSY);
  localparam logic [2:0] ST_I_RESP = 3'(I_RESP);
  localparam logic [2:0] ST_D_RESP = 3'(D_RESP);

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and the memory port.
import cache_arbiter_pkg::*;

interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH = LINE_WIDTH_DEF
);

  logic [ADDR_WIDTH-1:0] icache_pmem_address;
  logic                  icache_pmem_read;
  logic                  icache_pmem_resp;
  logic [LINE_WIDTH-1:0] icache_pmem_rdata;

  logic [ADDR_WIDTH-1:0] dcache_pmem_address;
  logic                  dcache_pmem_read;
  logic                  dcache_pmem_write;
  logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
  logic                  dcache_pmem_resp;
  logic [LINE_WIDTH-1:0] dcache_pmem_rdata;

  logic [ADDR_WIDTH-1:0] pmem_address;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  logic                  arb_busy;

  // Arbiter side.
  modport slave (
    input  icache_pmem_address, icache_pmem_read,
    output icache_pmem_resp, icache_pmem_rdata,
    input  dcache_pmem_address, dcache_pmem_read, dcache_pmem_write, dcache_pmem_wdata,
    output dcache_pmem_resp, dcache_pmem_rdata,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output arb_busy
  );

  // Environment side: both caches plus the memory.
  modport master (
    output icache_pmem_address, icache_pmem_read,
    input  icache_pmem_resp, icache_pmem_rdata,
    output dcache_pmem_address, dcache_pmem_read, dcache_pmem_write, dcache_pmem_wdata,
    input  dcache_pmem_resp, dcache_pmem_rdata,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  arb_busy
  );

endinterface

// File: rtl/cache_arbiter_arb_priority.sv
// Grant selection between icache and dcache with an icache starvation guard.
import cache_arbiter_pkg::*;

module arb_priority #(
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic grant_en,
  output logic grant_i,
  output logic grant_d
);

  localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  // Number of consecutive dcache grants won while the icache was also waiting.
  logic [STREAK_W-1:0] d_streak;
  logic                i_starved;

  assign i_starved = (d_streak == STREAK_MAX);

  // dcache wins unless the icache is waiting and has already lost MAX_D_STREAK times.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (grant_en) begin
      if (d_req && !(i_req && i_starved)) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // Saturating streak: bumps only on contested dcache grants, clears on any icache grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_streak <= '0;
    end else if (grant_i) begin
      d_streak <= '0;
    end else if (grant_d && i_req && !i_starved) begin
      d_streak <= d_streak + 1'b1;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Single-port memory arbiter for icache fills and dcache fills/writebacks.
// Requests are latched at grant; strobes and responses are registered.
import cache_arbiter_pkg::*;

module cache_arbiter #(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int LINE_WIDTH   = LINE_WIDTH_DEF,
  parameter int OFFSET_BITS  = OFFSET_BITS_DEF,
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
  input logic           clk,
  input logic           reset,
  cache_arbiter_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << OFFSET_BITS) - 1);

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
    return a & ~OFFSET_MASK;
  endfunction

  logic [2:0]            state;
  logic                  in_idle;
  logic                  d_req;
  logic                  grant_i;
  logic                  grant_d;

  logic                  pmem_read_q;
  logic                  pmem_write_q;
  logic                  icache_resp_q;
  logic                  dcache_resp_q;
  logic [ADDR_WIDTH-1:0] pmem_address_q;
  logic [LINE_WIDTH-1:0] pmem_wdata_q;
  logic [LINE_WIDTH-1:0] icache_rdata_q;
  logic [LINE_WIDTH-1:0] dcache_rdata_q;

  assign in_idle = (state == ST_IDLE);
  assign d_req   = bus.dcache_pmem_read | bus.dcache_pmem_write;

  arb_priority #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_prio (
    .clk      (clk),
    .reset    (reset),
    .i_req    (bus.icache_pmem_read),
    .d_req    (d_req),
    .grant_en (in_idle),
    .grant_i  (grant_i),
    .grant_d  (grant_d)
  );

  // FSM: grant in IDLE, hold strobe until pmem_resp, then one response cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      pmem_read_q   <= 1'b0;
      pmem_write_q  <= 1'b0;
      icache_resp_q <= 1'b0;
      dcache_resp_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            // A simultaneous read+write from the dcache is treated as a writeback.
            state        <= ST_D_BUSY;
            pmem_write_q <= bus.dcache_pmem_write;
            pmem_read_q  <= ~bus.dcache_pmem_write;
          end else if (grant_i) begin
            state        <= ST_I_BUSY;
            pmem_read_q  <= 1'b1;
            pmem_write_q <= 1'b0;
          end
        end
        ST_I_BUSY: begin
          if (bus.pmem_resp) begin
            state         <= ST_I_RESP;
            pmem_read_q   <= 1'b0;
            pmem_write_q  <= 1'b0;
            icache_resp_q <= 1'b1;
          end
        end
        ST_D_BUSY: begin
          if (bus.pmem_resp) begin
            state         <= ST_D_RESP;
            pmem_read_q   <= 1'b0;
            pmem_write_q  <= 1'b0;
            dcache_resp_q <= 1'b1;
          end
        end
        ST_I_RESP, ST_D_RESP: begin
          state         <= ST_IDLE;
          icache_resp_q <= 1'b0;
          dcache_resp_q <= 1'b0;
        end
        default: begin
          state         <= ST_IDLE;
          pmem_read_q   <= 1'b0;
          pmem_write_q  <= 1'b0;
          icache_resp_q <= 1'b0;
          dcache_resp_q <= 1'b0;
        end
      endcase
    end
  end

  // Grant-time latches and per-requester fill buffers; requester inputs are ignored after grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      icache_rdata_q <= '0;
      dcache_rdata_q <= '0;
    end else begin
      if (grant_d) begin
        pmem_address_q <= line_align(bus.dcache_pmem_address);
        pmem_wdata_q   <= bus.dcache_pmem_wdata;
      end else if (grant_i) begin
        pmem_address_q <= line_align(bus.icache_pmem_address);
      end
      if (bus.pmem_resp && (state == ST_I_BUSY)) begin
        icache_rdata_q <= bus.pmem_rdata;
      end
      // Writebacks return nothing, so the dcache buffer keeps its previous fill.
      if (bus.pmem_resp && (state == ST_D_BUSY) && !pmem_write_q) begin
        dcache_rdata_q <= bus.pmem_rdata;
      end
    end
  end

  assign bus.pmem_address      = pmem_address_q;
  assign bus.pmem_read         = pmem_read_q;
  assign bus.pmem_write        = pmem_write_q;
  assign bus.pmem_wdata        = pmem_wdata_q;
  assign bus.icache_pmem_resp  = icache_resp_q;
  assign bus.icache_pmem_rdata = icache_rdata_q;
  assign bus.dcache_pmem_resp  = dcache_resp_q;
  assign bus.dcache_pmem_rdata = dcache_rdata_q;
  assign bus.arb_busy          = ~in_idle;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed request scenarios, a transaction-level
// reference model checked every cycle, and literal spot checks.
`timescale 1ns/1ps
import cache_arbiter_pkg::*;

module tb_cache_arbiter;

  localparam int AW   = 16;
  localparam int LW   = 128;
  localparam int OB   = 4;
  localparam int MAXS = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  cache_arbiter #(
    .ADDR_WIDTH   (AW),
    .LINE_WIDTH   (LW),
    .OFFSET_BITS  (OB),
    .MAX_D_STREAK (MAXS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int       mem_lat   = 1;
  int       mem_cnt   = 0;
  bit       mem_fixed = 1'b0;
  lc3b_line mem_pat   = '0;
  bit       spurious  = 1'b0;

  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.pmem_read || bus.pmem_write) begin
        mem_cnt        = mem_cnt + 1;
        bus.pmem_resp  = (mem_cnt == mem_lat);
        bus.pmem_rdata = mem_fixed ? mem_pat : {8{bus.pmem_address}};
      end else begin
        mem_cnt        = 0;
        bus.pmem_resp  = spurious;
        bus.pmem_rdata = {16{8'hEE}};
      end
    end
  end

  // ---------------- reference model ----------------
  // m_phase: 0 free, 1 transaction on memory, 2 response cycle.
  int          m_phase;
  bit          m_own_d;
  bit          m_write;
  logic [15:0] m_addr;
  lc3b_line    m_wdata;
  lc3b_line    m_irdata;
  lc3b_line    m_drdata;
  int          m_streak;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase  <= 0;
      m_own_d  <= 1'b0;
      m_write  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_irdata <= '0;
      m_drdata <= '0;
      m_streak <= 0;
    end else if (m_phase == 0) begin
      if (bus.icache_pmem_read || bus.dcache_pmem_read || bus.dcache_pmem_write) begin
        m_phase <= 1;
        if ((bus.dcache_pmem_read || bus.dcache_pmem_write) &&
            (!bus.icache_pmem_read || m_streak < MAXS)) begin
          m_own_d <= 1'b1;
          m_addr  <= bus.dcache_pmem_address & 16'hFFF0;
          m_write <= bus.dcache_pmem_write;
          m_wdata <= bus.dcache_pmem_wdata;
          if (bus.icache_pmem_read && m_streak < MAXS) m_streak <= m_streak + 1;
        end else begin
          m_own_d  <= 1'b0;
          m_addr   <= bus.icache_pmem_address & 16'hFFF0;
          m_write  <= 1'b0;
          m_streak <= 0;
        end
      end
    end else if (m_phase == 1) begin
      if (bus.pmem_resp) begin
        m_phase <= 2;
        if (!m_write) begin
          if (m_own_d) m_drdata <= bus.pmem_rdata;
          else         m_irdata <= bus.pmem_rdata;
        end
      end
    end else begin
      m_phase <= 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("pmem_read",    bus.pmem_read,    128'((m_phase == 1) && !m_write));
      check("pmem_write",   bus.pmem_write,   128'((m_phase == 1) && m_write));
      check("pmem_address", bus.pmem_address, m_addr);
      if (bus.pmem_write) check("pmem_wdata", bus.pmem_wdata, m_wdata);
      check("icache_resp",  bus.icache_pmem_resp, 128'((m_phase == 2) && !m_own_d));
      check("dcache_resp",  bus.dcache_pmem_resp, 128'((m_phase == 2) && m_own_d));
      check("icache_rdata", bus.icache_pmem_rdata, m_irdata);
      check("dcache_rdata", bus.dcache_pmem_rdata, m_drdata);
      check("arb_busy",     bus.arb_busy, 128'(m_phase != 0));
      check("resp_onehot",  bus.icache_pmem_resp & bus.dcache_pmem_resp, 0);
    end
  end

  // ---------------- observers ----------------
  int          rd_cycles = 0;
  int          wr_cycles = 0;
  int          iresp_cnt = 0;
  logic [15:0] glog[$];
  bit          prev_strobe = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.pmem_read)  rd_cycles++;
      if (bus.pmem_write) wr_cycles++;
      if (bus.icache_pmem_resp) iresp_cnt++;
      if ((bus.pmem_read || bus.pmem_write) && !prev_strobe) glog.push_back(bus.pmem_address);
      prev_strobe = bus.pmem_read || bus.pmem_write;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_resp(input bit d);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = d ? bus.dcache_pmem_resp : bus.icache_pmem_resp;
    end
    check(d ? "d_resp_seen" : "i_resp_seen", 128'(seen), 1);
  endtask

  task automatic wait_strobe(input bit w);
    bit seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = w ? bus.pmem_write : bus.pmem_read;
    end
    check(w ? "write_strobe_seen" : "read_strobe_seen", 128'(seen), 1);
  endtask

  task automatic req_i(input logic [15:0] a);
    bus.icache_pmem_address = a;
    bus.icache_pmem_read    = 1'b1;
    wait_resp(1'b0);
    tick();
    bus.icache_pmem_read = 1'b0;
  endtask

  task automatic req_d(input logic [15:0] a, input bit rd, input bit wr, input lc3b_line wd);
    bus.dcache_pmem_address = a;
    bus.dcache_pmem_read    = rd;
    bus.dcache_pmem_write   = wr;
    bus.dcache_pmem_wdata   = wd;
    wait_resp(1'b1);
    tick();
    bus.dcache_pmem_read  = 1'b0;
    bus.dcache_pmem_write = 1'b0;
  endtask

  logic [15:0] exp3 [6] = '{16'h5000, 16'h5010, 16'h5020, 16'h6000, 16'h5030, 16'h5040};

  // ---------------- directed scenarios ----------------
  initial begin
    int rd_base;
    int wr_base;
    int ir_base;
    int g_base;
    lc3b_line w2;
    lc3b_line w4;
    w2 = {4{32'hDEAD_0002}};
    w4 = {4{32'hBEEF_0004}};

    bus.icache_pmem_address = '0;
    bus.icache_pmem_read    = 1'b0;
    bus.dcache_pmem_address = '0;
    bus.dcache_pmem_read    = 1'b0;
    bus.dcache_pmem_write   = 1'b0;
    bus.dcache_pmem_wdata   = '0;

    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("rst_pmem_read",  bus.pmem_read, 0);
    check("rst_busy",       bus.arb_busy, 0);
    check("rst_irdata",     bus.icache_pmem_rdata, 0);
    check("rst_addr",       bus.pmem_address, 0);
    check("rst_streak",     dut.u_prio.d_streak, 0);

    // Lone icache read, 2-cycle memory.
    mem_fixed = 1'b1;
    mem_pat   = {16{8'hA5}};
    mem_lat   = 2;
    rd_base = rd_cycles; ir_base = iresp_cnt; g_base = glog.size();
    req_i(16'h1237);
    check("t1_addr",      glog[g_base], 16'h1230);
    check("t1_rd_cycles", rd_cycles - rd_base, 2);
    check("t1_resp_cnt",  iresp_cnt - ir_base, 1);
    check("t1_rdata",     bus.icache_pmem_rdata, {16{8'hA5}});
    mem_fixed = 1'b0;
    mem_lat   = 1;

    // Simultaneous icache read and dcache write: dcache first.
    g_base = glog.size();
    fork
      req_i(16'h0100);
      req_d(16'h2000, 1'b0, 1'b1, w2);
      begin
        wait_strobe(1'b1);
        check("t2_streak_after_d", dut.u_prio.d_streak, 1);
        check("t2_wdata",          bus.pmem_wdata, w2);
        wait_strobe(1'b0);
        check("t2_streak_after_i", dut.u_prio.d_streak, 0);
      end
    join
    check("t2_first",  glog[g_base],     16'h2000);
    check("t2_second", glog[g_base + 1], 16'h0100);
    check("t2_irdata", bus.icache_pmem_rdata, {8{16'h0100}});

    // Starvation guard: icache pending across five dcache reads.
    g_base = glog.size();
    fork
      req_i(16'h6006);
      begin
        for (int i = 0; i < 5; i++) req_d(16'(16'h5000 + i * 17), 1'b1, 1'b0, '0);
      end
    join
    check("t3_grants", glog.size() - g_base, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t3_grant%0d", i), glog[g_base + i], exp3[i]);
    check("t3_drdata", bus.dcache_pmem_rdata, {8{16'h5040}});

    // dcache read and write together: write only, fill buffer untouched.
    rd_base = rd_cycles; wr_base = wr_cycles; g_base = glog.size();
    req_d(16'h3008, 1'b1, 1'b1, w4);
    check("t4_addr",      glog[g_base], 16'h3000);
    check("t4_rd_cycles", rd_cycles - rd_base, 0);
    check("t4_wr_cycles", wr_cycles - wr_base, 1);
    check("t4_drdata",    bus.dcache_pmem_rdata, {8{16'h5040}});

    // Reset in the middle of a long writeback.
    mem_lat = 6;
    bus.dcache_pmem_address = 16'h7004;
    bus.dcache_pmem_write   = 1'b1;
    bus.dcache_pmem_wdata   = w4;
    wait_strobe(1'b1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t5_write_async", bus.pmem_write, 0);
    check("t5_busy_async",  bus.arb_busy, 0);
    check("t5_dresp",       bus.dcache_pmem_resp, 0);
    bus.dcache_pmem_write = 1'b0;
    tick();
    reset   = 1'b0;
    mem_lat = 1;
    tick();
    req_i(16'h4444);
    check("t5_after_rdata", bus.icache_pmem_rdata, {8{16'h4440}});

    // Spurious memory response while idle.
    tick();
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    tick();
    @(negedge clk);
    check("t6_iresp",  bus.icache_pmem_resp, 0);
    check("t6_dresp",  bus.dcache_pmem_resp, 0);
    check("t6_busy",   bus.arb_busy, 0);
    check("t6_irdata", bus.icache_pmem_rdata, {8{16'h4440}});

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
